// File: rtl/wb_arb_nm.sv
// N-master classic Wishbone arbiter: round-robin grant, m_cyc locking, one idle
// cycle between owners, and a watchdog that errors out a hung slave access.
module wb_arb_nm #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk_1x,
    input  logic               rst,
    input  logic [NM-1:0]      m_cyc,
    input  logic [NM-1:0]      m_stb,
    input  logic [NM-1:0]      m_we,
    input  logic [NM*AW-1:0]   m_adr,
    input  logic [NM*DW/8-1:0] m_sel,
    input  logic [NM*DW-1:0]   m_datw,
    output logic [NM-1:0]      m_ack,
    output logic [NM-1:0]      m_err,
    output logic [DW-1:0]      m_datr,
    output logic               wb_cyc,
    output logic               wb_stb,
    output logic               wb_we,
    output logic [AW-1:0]      wb_adr,
    output logic [DW/8-1:0]    wb_sel,
    output logic [DW-1:0]      wb_datw,
    input  logic               wb_ack,
    input  logic               wb_err,
    input  logic [DW-1:0]      wb_datr,
    output logic [NM-1:0]      grant,
    output logic               to_evt
);
    localparam int SW = DW / 8;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state, w_state_nx;
    logic [IW-1:0]   r_rr, w_rr_nx;
    logic [IW-1:0]   w_win, w_idx;
    logic            w_any;
    logic            w_busy;
    logic            w_abort;

    logic [AW-1:0]   w_adr_a  [NM];
    logic [SW-1:0]   w_sel_a  [NM];
    logic [DW-1:0]   w_datw_a [NM];

    for (genvar i = 0; i < NM; i++) begin : g_m
        assign w_adr_a[i]  = m_adr[i*AW +: AW];
        assign w_sel_a[i]  = m_sel[i*SW +: SW];
        assign w_datw_a[i] = m_datw[i*DW +: DW];
    end

    // r_rr is both the round-robin pointer and, while BUSY, the owner index.
    // Scanning from farthest to nearest lets the nearest requester after r_rr win.
    always_comb begin
        w_any = 1'b0;
        w_win = r_rr;
        w_idx = '0;
        for (int k = NM; k >= 1; k--) begin
            w_idx = IW'((int'(r_rr) + k) % NM);
            if (m_cyc[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_busy = (r_state == S_BUSY) && !rst;

    always_comb begin
        w_state_nx = r_state;
        w_rr_nx    = r_rr;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_state_nx = S_BUSY;
                w_rr_nx    = w_win;
            end
            S_BUSY: if (!m_cyc[r_rr] || w_abort) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1x) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= IW'(NM - 1);
        end else begin
            r_state <= w_state_nx;
            r_rr    <= w_rr_nx;
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int CW = $clog2(TIMEOUT + 1);
        logic [CW-1:0] r_cnt;
        logic          w_silent;

        assign w_silent = w_busy && m_cyc[r_rr] && m_stb[r_rr] && !wb_ack && !wb_err;
        assign w_abort  = w_silent && (r_cnt == CW'(TIMEOUT));

        always_ff @(posedge clk_1x) begin
            if (rst || !w_silent || w_abort) r_cnt <= '0;
            else if (r_cnt != CW'(TIMEOUT))  r_cnt <= r_cnt + CW'(1);
        end
    end else begin : g_nowd
        assign w_abort = 1'b0;
    end

    // The abort cycle drops cyc/stb so the slave sees the access withdrawn.
    assign wb_cyc  = w_busy && m_cyc[r_rr] && !w_abort;
    assign wb_stb  = w_busy && m_stb[r_rr] && !w_abort;
    assign wb_we   = w_busy && m_we[r_rr];
    assign wb_adr  = w_busy ? w_adr_a[r_rr]  : '0;
    assign wb_sel  = w_busy ? w_sel_a[r_rr]  : '0;
    assign wb_datw = w_busy ? w_datw_a[r_rr] : '0;
    assign m_datr  = wb_datr;
    assign to_evt  = w_abort;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        grant = '0;
        if (r_state == S_BUSY) grant[r_rr] = 1'b1;
        if (w_busy) begin
            m_ack[r_rr] = wb_ack;
            m_err[r_rr] = wb_err || w_abort;
        end
    end
endmodule

// File: tb/tb_wb_arb_nm.sv
// Directed bench for wb_arb_nm (4 masters, TIMEOUT=8) with a per-cycle reference
// model of ownership, round-robin order and the silent-strobe watchdog.
module tb_wb_arb_nm;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic               clk_1x = 1'b0;
    logic               rst;
    logic [NM-1:0]      m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*SW-1:0]   m_sel;
    logic [NM*DW-1:0]   m_datw;
    logic [NM-1:0]      m_ack, m_err, grant;
    logic [DW-1:0]      m_datr;
    logic               wb_cyc, wb_stb, wb_we, wb_ack, wb_err, to_evt;
    logic [AW-1:0]      wb_adr;
    logic [SW-1:0]      wb_sel;
    logic [DW-1:0]      wb_datw, wb_datr;

    int errors = 0;
    int checks = 0;

    wb_arb_nm #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_1x(clk_1x), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_datw(m_datw), .m_ack(m_ack), .m_err(m_err), .m_datr(m_datr),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_datw(wb_datw), .wb_ack(wb_ack), .wb_err(wb_err),
        .wb_datr(wb_datr), .grant(grant), .to_evt(to_evt)
    );

    always #5 clk_1x = ~clk_1x;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_1x);
        #1;
    endtask

    task automatic set_m(input int i, input bit c, input bit s, input bit w,
                         input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
        m_cyc[i] = c;
        m_stb[i] = s;
        m_we[i]  = w;
        m_adr[i*AW +: AW]  = a;
        m_sel[i*SW +: SW]  = sl;
        m_datw[i*DW +: DW] = d;
    endtask

    // Reference model: owner (-1 = none), last winner, silent strobe cycles so far.
    int mo, mrr, mcnt;

    initial begin
        @(posedge clk_1x);
        mo = -1; mrr = NM - 1; mcnt = 0;
        forever begin
            logic [NM-1:0] e_ack, e_err, e_gnt;
            logic          e_cyc, e_stb, e_we, e_to, tmo, found;
            logic [AW-1:0] e_adr;
            logic [SW-1:0] e_sel;
            logic [DW-1:0] e_datw;
            int            cand;
            @(negedge clk_1x);
            e_ack = '0; e_err = '0; e_gnt = '0;
            e_cyc = 0; e_stb = 0; e_we = 0; e_to = 0; tmo = 0;
            e_adr = '0; e_sel = '0; e_datw = '0;
            if (mo >= 0) e_gnt[2'(mo)] = 1'b1;
            if (!rst && mo >= 0) begin
                tmo    = (mcnt >= TO) && m_cyc[2'(mo)] && m_stb[2'(mo)] && !wb_ack && !wb_err;
                e_cyc  = m_cyc[2'(mo)] && !tmo;
                e_stb  = m_stb[2'(mo)] && !tmo;
                e_we   = m_we[2'(mo)];
                e_adr  = m_adr[mo*AW +: AW];
                e_sel  = m_sel[mo*SW +: SW];
                e_datw = m_datw[mo*DW +: DW];
                e_ack[2'(mo)] = wb_ack;
                e_err[2'(mo)] = wb_err || tmo;
                e_to   = tmo;
            end
            chk("grant",   grant,   e_gnt);
            chk("wb_cyc",  wb_cyc,  e_cyc);
            chk("wb_stb",  wb_stb,  e_stb);
            chk("wb_we",   wb_we,   e_we);
            chk("wb_adr",  wb_adr,  e_adr);
            chk("wb_sel",  wb_sel,  e_sel);
            chk("wb_datw", wb_datw, e_datw);
            chk("m_ack",   m_ack,   e_ack);
            chk("m_err",   m_err,   e_err);
            chk("to_evt",  to_evt,  e_to);
            chk("m_datr",  m_datr,  wb_datr);
            if (rst) begin
                mo = -1; mrr = NM - 1; mcnt = 0;
            end else if (mo < 0) begin
                found = 0;
                for (int k = 1; k <= NM; k++) begin
                    cand = (mrr + k) % NM;
                    if (!found && m_cyc[2'(cand)]) begin
                        found = 1; mo = cand; mrr = cand;
                    end
                end
                mcnt = 0;
            end else if (tmo || !m_cyc[2'(mo)]) begin
                mo = -1; mcnt = 0;
            end else if (m_stb[2'(mo)] && !wb_ack && !wb_err) begin
                mcnt++;
            end else begin
                mcnt = 0;
            end
        end
    end

    initial begin
        rst = 1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_datw = '0;
        wb_ack = 0; wb_err = 0; wb_datr = 32'h0;
        step(); @(negedge clk_1x);
        chk("rst_grant", grant, 0); chk("rst_wbcyc", wb_cyc, 0); chk("rst_to", to_evt, 0);

        // single request
        step(); rst = 0; set_m(0, 1, 1, 1, 32'h1000, 4'hF, 32'hDEADBEEF);
        @(negedge clk_1x); chk("s1_t0_grant", grant, 0); chk("s1_t0_cyc", wb_cyc, 0);
        step(); @(negedge clk_1x);
        chk("s1_grant", grant, 4'b0001); chk("s1_adr", wb_adr, 32'h1000);
        chk("s1_datw", wb_datw, 32'hDEADBEEF);
        step(); @(negedge clk_1x);
        step(); wb_ack = 1; @(negedge clk_1x); chk("s1_ack", m_ack, 4'b0001);
        step(); wb_ack = 0; set_m(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_1x); chk("s1_drop_cyc", wb_cyc, 0);
        step(); @(negedge clk_1x); chk("s1_idle_grant", grant, 0);

        // round robin from reset
        step(); rst = 1; @(negedge clk_1x);
        step(); rst = 0;
        for (int i = 0; i < NM; i++) set_m(i, 1, 1, 0, 32'h2000 + 32'(i * 16), 4'hF, 0);
        @(negedge clk_1x); chk("rr_idle0", grant, 0);
        for (int k = 0; k < 5; k++) begin
            step(); wb_ack = 1; @(negedge clk_1x);
            chk("rr_grant", grant, 4'b0001 << (k % NM));
            chk("rr_ack", m_ack, 4'b0001 << (k % NM));
            step(); wb_ack = 0; set_m(k % NM, 0, 0, 0, 0, 0, 0);
            @(negedge clk_1x); chk("rr_drop", wb_cyc, 0);
            step(); set_m(k % NM, 1, 1, 0, 32'h2000 + 32'((k % NM) * 16), 4'hF, 0);
            @(negedge clk_1x); chk("rr_gap", grant, 0);
        end
        step(); m_cyc = '0; m_stb = '0; @(negedge clk_1x); chk("rr_end", wb_cyc, 0);
        step(); @(negedge clk_1x);

        // lock: master1 holds while master0 waits
        step(); set_m(1, 1, 1, 0, 32'h3000, 4'hF, 0);
        @(negedge clk_1x); chk("lk_idle", grant, 0);
        step(); set_m(0, 1, 1, 0, 32'h4000, 4'hF, 0); wb_ack = 1; wb_datr = 32'h12345678;
        @(negedge clk_1x); chk("lk_g1", grant, 4'b0010); chk("lk_datr1", m_datr, 32'h12345678);
        chk("lk_ack1", m_ack, 4'b0010);
        step(); wb_ack = 0; m_stb[1] = 0; @(negedge clk_1x); chk("lk_hold", grant, 4'b0010);
        step(); m_stb[1] = 1; wb_err = 1; @(negedge clk_1x); chk("lk_err", m_err, 4'b0010);
        step(); wb_err = 0; wb_ack = 1; wb_datr = 32'hCAFEF00D;
        @(negedge clk_1x); chk("lk_datr3", m_datr, 32'hCAFEF00D); chk("lk_g3", grant, 4'b0010);
        step(); wb_ack = 0; set_m(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_1x); chk("lk_drop", wb_cyc, 0);
        step(); @(negedge clk_1x); chk("lk_gap", grant, 0);
        step(); wb_ack = 1; wb_datr = 32'h0BADF00D;
        @(negedge clk_1x); chk("lk_g0", grant, 4'b0001); chk("lk_ack0", m_ack, 4'b0001);
        step(); wb_ack = 0; set_m(0, 0, 0, 0, 0, 0, 0); @(negedge clk_1x);
        step(); @(negedge clk_1x);

        // timeout on master2
        step(); set_m(2, 1, 1, 1, 32'h5000, 4'h3, 32'h55AA55AA); @(negedge clk_1x);
        step(); set_m(3, 1, 1, 0, 32'h6000, 4'hF, 0);
        @(negedge clk_1x); chk("to_g2", grant, 4'b0100);
        for (int k = 1; k < TO; k++) begin
            step(); @(negedge clk_1x); chk("to_quiet", to_evt, 0);
        end
        step(); @(negedge clk_1x);
        chk("to_err", m_err, 4'b0100); chk("to_evt", to_evt, 1); chk("to_cyc", wb_cyc, 0);
        step(); set_m(2, 0, 0, 0, 0, 0, 0); @(negedge clk_1x); chk("to_gap", grant, 0);
        step(); wb_ack = 1; @(negedge clk_1x); chk("to_next", grant, 4'b1000);
        step(); wb_ack = 0; set_m(3, 0, 0, 0, 0, 0, 0); @(negedge clk_1x);
        step(); @(negedge clk_1x);

        // ack races the abort cycle
        step(); set_m(1, 1, 1, 0, 32'h7000, 4'hF, 0); @(negedge clk_1x);
        step(); @(negedge clk_1x); chk("rc_g1", grant, 4'b0010);
        for (int k = 1; k < TO; k++) begin
            step(); @(negedge clk_1x);
        end
        step(); wb_ack = 1; wb_datr = 32'hA5A5A5A5; @(negedge clk_1x);
        chk("rc_ack", m_ack, 4'b0010); chk("rc_err", m_err, 0); chk("rc_to", to_evt, 0);
        step(); wb_ack = 0; set_m(1, 0, 0, 0, 0, 0, 0); @(negedge clk_1x);
        step(); @(negedge clk_1x);

        // reset while master0 owns with a live strobe
        step(); set_m(0, 1, 1, 1, 32'h8000, 4'hF, 32'h11112222); @(negedge clk_1x);
        step(); @(negedge clk_1x); chk("rs_g0", grant, 4'b0001); chk("rs_stb", wb_stb, 1);
        step(); rst = 1; wb_ack = 1; @(negedge clk_1x); chk("rs_inrst_ack", m_ack, 0);
        step(); rst = 0; wb_ack = 0; set_m(1, 1, 1, 0, 32'h9000, 4'hF, 0);
        @(negedge clk_1x);
        chk("rs_cyc", wb_cyc, 0); chk("rs_grant", grant, 0);
        chk("rs_ack", m_ack, 0); chk("rs_err", m_err, 0);
        step(); @(negedge clk_1x); chk("rs_first", grant, 4'b0001);
        step(); m_cyc = '0; m_stb = '0; @(negedge clk_1x);
        step(); @(negedge clk_1x);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
